// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for a standard-mode FIFO: issues reads, hides the one-cycle
// read latency in a small prefetch buffer and emits fixed-length framed stream bursts.
module fifo_rd_stream #(
  parameter int DATA_WIDTH      = 32,
  parameter int BUF_DEPTH       = 4,
  parameter int BURST_LEN       = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                               rd_clk,
  input  logic                               rst,
  input  logic                               fifo_empty,
  input  logic                               fifo_valid,
  input  logic [DATA_WIDTH-1:0]              fifo_dout,
  output logic                               fifo_rd_en,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic                               m_last,
  output logic [FRAME_CNT_WIDTH-1:0]         frame_cnt,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_level,
  output logic                               ovf_err
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int LW = $clog2(BUF_DEPTH + 1);
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LW-1:0] OCC_FULL  = LW'(BUF_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0]      mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]      mem_d [BUF_DEPTH];
  logic [AW-1:0]              hptr_q, hptr_d, tptr_q, tptr_d;
  logic [LW-1:0]              occ_q, occ_d;
  logic                       pend_q, pend_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       ovf_q, ovf_d;
  logic                       rd_en_c, pop_c, push_ok_c;

  // Stream handshake: a beat transfers on a cycle where m_valid && m_ready; once
  // m_valid is high, m_data/m_last stay put until that transfer happens.
  always_comb begin
    rd_en_c   = !rst && !fifo_empty &&
                (({1'b0, occ_q} + {{LW{1'b0}}, pend_q}) < (LW + 1)'(BUF_DEPTH));
    pop_c     = (occ_q != '0) && m_ready;
    // At full, an incoming word is only kept if a beat leaves in the same cycle.
    push_ok_c = fifo_valid && ((occ_q != OCC_FULL) || pop_c);

    mem_d = mem_q;
    if (push_ok_c) mem_d[tptr_q] = fifo_dout;

    tptr_d      = tptr_q + AW'(push_ok_c);
    hptr_d      = hptr_q + AW'(pop_c);
    occ_d       = occ_q + LW'(push_ok_c) - LW'(pop_c);
    pend_d      = rd_en_c;
    ovf_d       = ovf_q | (fifo_valid && !push_ok_c);
    beat_d      = beat_q;
    frame_cnt_d = frame_cnt_q;
    if (pop_c) begin
      if (beat_q == BEAT_LAST) begin
        beat_d      = '0;
        frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      hptr_q      <= '0;
      tptr_q      <= '0;
      occ_q       <= '0;
      pend_q      <= 1'b0;
      beat_q      <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= mem_d[i];
      hptr_q      <= hptr_d;
      tptr_q      <= tptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      beat_q      <= beat_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    fifo_rd_en = rd_en_c;
    m_valid    = (occ_q != '0);
    m_data     = mem_q[hptr_q];
    m_last     = (occ_q != '0) && (beat_q == BEAT_LAST);
    frame_cnt  = frame_cnt_q;
    buf_level  = occ_q;
    ovf_err    = ovf_q;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural source FIFO, scoreboard queue,
// per-cycle flow checks and hand-computed scenario checks.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rst;
  logic        fifo_empty, fifo_valid, m_ready;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en, m_valid, m_last, ovf_err;
  logic [31:0] m_data;
  logic [15:0] frame_cnt;
  logic [2:0]  buf_level;
  logic        b_rd_en, b_valid, b_last, b_ovf;
  logic [31:0] b_data;
  logic [1:0]  b_frame;
  logic [2:0]  b_level;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_stream #(.DATA_WIDTH(32), .BUF_DEPTH(4), .BURST_LEN(16), .FRAME_CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .frame_cnt(frame_cnt), .buf_level(buf_level),
    .ovf_err(ovf_err)
  );

  // Same input stream, single-beat frames and a 2-bit frame counter.
  fifo_rd_stream #(.DATA_WIDTH(32), .BUF_DEPTH(4), .BURST_LEN(1), .FRAME_CNT_WIDTH(2)) dut_b (
    .rd_clk(rd_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_dout(fifo_dout), .fifo_rd_en(b_rd_en), .m_valid(b_valid), .m_ready(m_ready),
    .m_data(b_data), .m_last(b_last), .frame_cnt(b_frame), .buf_level(b_level),
    .ovf_err(b_ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int          tb_occ, tb_beat, tb_frames, tb_pops_rst;
  bit          tb_ovf, pend_v;
  logic [31:0] pend_w;
  bit          force_valid;
  logic [31:0] force_word;
  bit          prev_stall, prev_last, prev_pop;
  logic [31:0] prev_data;
  int          cyc, rd_pulses, pops, last_count, first_last_idx, max_level;
  int          first_rd_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  logic [1:0]  b_seq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    rd_pulses = 0; pops = 0; last_count = 0; first_last_idx = -1; max_level = 0;
    first_rd_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    b_seq.delete();
  endtask

  // One cycle: drive inputs just after the falling edge, then sample and check.
  task automatic step_body(input bit rdy);
    bit pop;
    if (force_valid) begin
      fifo_valid = 1'b1; fifo_dout = force_word; force_word++;
    end else begin
      fifo_valid = pend_v; fifo_dout = pend_w;
    end
    fifo_empty = (src_q.size() == 0);
    m_ready    = rdy;
    #1;
    if (prev_pop) b_seq.push_back(b_frame);
    check("buf_level", buf_level, tb_occ);
    check("m_valid", m_valid, tb_occ != 0);
    check("rd_en", fifo_rd_en, !fifo_empty && ((tb_occ + int'(pend_v)) < 4));
    check("ovf_err", ovf_err, tb_ovf);
    check("frame_cnt", frame_cnt, tb_frames[15:0]);
    check("m_last", m_last, m_valid && (tb_beat == 15));
    check("b_frame", b_frame, tb_pops_rst % 4);
    check("b_last", b_last, b_valid);
    check("b_valid", b_valid, m_valid);
    if (prev_stall) begin
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (int'(buf_level) > max_level) max_level = int'(buf_level);
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    pop = m_valid && m_ready;
    if (pop) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("m_data", m_data, exp_q.pop_front());
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      if (m_last) begin
        last_count++;
        if (first_last_idx < 0) first_last_idx = pops;
      end
      if (tb_beat == 15) begin tb_beat = 0; tb_frames++; end
      else tb_beat++;
      tb_pops_rst++;
    end
    prev_pop   = pop;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
    if (fifo_valid) begin
      if (tb_occ == 4 && !pop) tb_ovf = 1'b1;
      else begin exp_q.push_back(fifo_dout); tb_occ++; end
    end
    if (pop) tb_occ--;
    if (fifo_rd_en) begin
      rd_pulses++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      if (src_q.size() == 0) begin check("rd_when_empty", 1, 0); pend_v = 1'b0; end
      else begin pend_w = src_q.pop_front(); pend_v = 1'b1; end
    end else begin
      pend_v = 1'b0;
    end
  endtask

  task automatic cycle(input bit rdy);
    @(negedge rd_clk);
    cyc++;
    step_body(rdy);
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    #2;
    rst = 1'b1;
    fifo_valid = 1'b0;
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_buf_level", buf_level, 0);
    check("rst_ovf_err", ovf_err, 0);
    check("rst_b_frame", b_frame, 0);
    exp_q.delete();
    tb_occ = 0; tb_beat = 0; tb_frames = 0; tb_pops_rst = 0; tb_ovf = 1'b0;
    pend_v = 1'b0; prev_stall = 1'b0; prev_pop = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    check("rst_hold_valid", m_valid, 0);
    @(negedge rd_clk);
    cyc++;
    rst = 1'b0;
    step_body(1'b0);
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (src_q.size() != 0 || pend_v || tb_occ != 0); k++) cycle(1'b1);
    check("drain_done", (src_q.size() == 0) && !pend_v && (tb_occ == 0), 1);
  endtask

  initial begin
    int lvl_exp[6];
    int ovf_exp[6];
    logic [1:0] wrap_exp[5];
    lvl_exp  = '{0, 1, 2, 3, 4, 4};
    ovf_exp  = '{0, 0, 0, 0, 0, 1};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst = 1'b0; fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_dout = '0; m_ready = 1'b0;
    force_valid = 1'b0; force_word = 32'hA0; pend_w = '0; cyc = 0;
    clear_stats();
    do_reset();

    // Steady stream: 48 words, ready always high.
    clear_stats();
    for (int i = 0; i < 48; i++) src_q.push_back(32'(i));
    for (int k = 0; k < 200 && pops < 48; k++) cycle(1'b1);
    check("steady_pops", pops, 48);
    check("steady_latency", first_valid_cyc - first_rd_cyc, 2);
    check("steady_back_to_back", last_pop_cyc - first_pop_cyc, 47);
    check("steady_last_count", last_count, 3);
    check("steady_first_last", first_last_idx, 16);
    cycle(1'b1);
    check("steady_frames", frame_cnt, 3);
    check("steady_ovf", ovf_err, 0);

    // Empty boundary: three words only, then the source stays empty.
    clear_stats();
    for (int i = 0; i < 3; i++) src_q.push_back(32'(200 + i));
    for (int k = 0; k < 20; k++) cycle(1'b1);
    check("empty_rd_pulses", rd_pulses, 3);
    check("empty_pops", pops, 3);
    check("empty_last_count", last_count, 0);
    check("empty_frames", frame_cnt, 3);

    // Back-pressure: ready pattern 1,0,0,1; frame resumes at beat 3.
    clear_stats();
    for (int i = 0; i < 45; i++) src_q.push_back(32'(300 + i));
    for (int k = 0; k < 400 && pops < 45; k++) begin
      int ph;
      ph = k % 4;
      cycle((ph == 0) || (ph == 3));
    end
    check("bp_pops", pops, 45);
    check("bp_first_last", first_last_idx, 13);
    check("bp_last_count", last_count, 3);
    check("bp_max_level", max_level <= 4, 1);
    cycle(1'b0);
    check("bp_frames", frame_cnt, 6);

    // Reset after 7 beats of a frame; the next frame counts from zero.
    clear_stats();
    for (int i = 0; i < 40; i++) src_q.push_back(32'(400 + i));
    for (int k = 0; k < 50 && pops < 7; k++) cycle(1'b1);
    check("mid_pops", pops, 7);
    do_reset();
    clear_stats();
    for (int k = 0; k < 100 && pops < 16; k++) cycle(1'b1);
    check("mid_after_pops", pops, 16);
    check("mid_first_last", first_last_idx, 16);
    cycle(1'b0);
    check("mid_frames", frame_cnt, 1);
    drain(200);

    // Overflow: six forced pushes with ready low.
    clear_stats();
    force_valid = 1'b1;
    for (int j = 0; j < 6; j++) begin
      cycle(1'b0);
      check("ovf_level_step", buf_level, lvl_exp[j]);
      check("ovf_flag_step", ovf_err, ovf_exp[j]);
    end
    force_valid = 1'b0;
    cycle(1'b0);
    check("ovf_level_sat", buf_level, 4);
    check("ovf_flag_set", ovf_err, 1);
    for (int k = 0; k < 8; k++) cycle(1'b1);
    check("ovf_drained", pops, 4);
    check("ovf_sticky", ovf_err, 1);
    do_reset();

    // Frame counter wrap on the single-beat, 2-bit-counter instance.
    clear_stats();
    for (int i = 0; i < 5; i++) src_q.push_back(32'(500 + i));
    for (int k = 0; k < 40 && pops < 5; k++) cycle(1'b1);
    cycle(1'b0);
    check("wrap_pops", pops, 5);
    check("wrap_seq_len", b_seq.size(), 5);
    for (int i = 0; i < 5 && i < b_seq.size(); i++) check("wrap_seq", b_seq[i], wrap_exp[i]);
    check("wrap_final", b_frame, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
